// File: rtl/eth_rx_manchester.sv
// Oversampled 10BASE-T Manchester receiver: preamble/SFD hunt, LSB-first byte assembly, frame-end marking.
// Latency: bit decided 3 cycles after an rx_in edge; byte n enters the FIFO when byte n+1 completes (final byte on carrier loss).
// Backpressure: out_valid/out_ready on the FIFO head; a push into a full FIFO is dropped and sets sticky overflow.

module eth_rx_manchester_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_vld,
    input  logic [WIDTH-1:0] push_dat,
    output logic             head_vld,
    input  logic             head_rdy,
    output logic [WIDTH-1:0] head_dat,
    output logic             drop
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             full;
    logic             pop;
    logic             push_ok;

    assign full     = (count == FULL_CNT);
    assign head_vld = (count != '0);
    assign pop      = head_vld & head_rdy;
    // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
    assign push_ok  = push_vld & (~full | pop);
    assign drop     = push_vld & full & ~pop;
    assign head_dat = head_vld ? mem[rd_ptr] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (push_ok && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push_ok) begin
                count <= count - CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_dat;
        end
    end
endmodule

module eth_rx_manchester #(
    parameter int OVERSAMPLE   = 8,
    parameter int FIFO_DEPTH   = 16,
    parameter int MIN_PREAMBLE = 16,
    parameter int IDLE_BITS    = 2
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       rx_in,
    output logic [7:0] out_data,
    output logic       out_last,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       overflow,
    output logic       activity
);
    localparam int LOSS    = OVERSAMPLE * IDLE_BITS;
    localparam int MID_THR = (3 * OVERSAMPLE) / 4;
    localparam int SW      = $clog2(LOSS + 1);
    localparam int AW      = $clog2(MIN_PREAMBLE + 1);
    localparam logic [SW-1:0] LOSS_V  = SW'(LOSS);
    localparam logic [SW-1:0] THR_V   = SW'(MID_THR);
    localparam logic [AW-1:0] ALT_MAX = AW'(MIN_PREAMBLE);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PREAMBLE,
        ST_HUNT,
        ST_DATA
    } state_t;

    typedef struct packed {
        logic       last;
        logic [7:0] data;
    } rx_entry_t;

    logic       sync_a;
    logic       sync_b;
    logic       line_q;
    logic       edge_q;
    logic       bit_q;
    logic [2:0] primed;

    // primed masks the edge detector until the synchroniser holds real line samples.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sync_a <= 1'b0;
            sync_b <= 1'b0;
            line_q <= 1'b0;
            edge_q <= 1'b0;
            bit_q  <= 1'b0;
            primed <= '0;
        end else begin
            sync_a <= rx_in;
            sync_b <= sync_a;
            line_q <= sync_b;
            primed <= {primed[1:0], 1'b1};
            edge_q <= primed[2] & (sync_b ^ line_q);
            bit_q  <= sync_b;
        end
    end

    state_t         state;
    state_t         state_nxt;
    logic [SW-1:0]  since_edge;
    logic [SW-1:0]  since_nxt;
    logic [AW-1:0]  alt_cnt;
    logic [AW-1:0]  alt_nxt;
    logic           prev_bit;
    logic           prev_nxt;
    logic [2:0]     bit_cnt;
    logic [2:0]     bcnt_nxt;
    logic [7:0]     shift_q;
    logic [7:0]     shift_nxt;
    logic [7:0]     stage_dat;
    logic [7:0]     stage_dat_nxt;
    logic           stage_full;
    logic           stage_full_nxt;
    logic           mid_edge;
    logic           carrier_loss;
    logic           push_vld;
    rx_entry_t      push_dat;
    rx_entry_t      head_dat;
    logic           drop;

    // Edges arriving well before a full bit time are bit-boundary transitions.
    assign mid_edge     = edge_q & ((state == ST_IDLE) | (since_edge >= THR_V));
    assign carrier_loss = (state != ST_IDLE) & (since_edge == LOSS_V);
    assign activity     = (state != ST_IDLE);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state      <= ST_IDLE;
            since_edge <= LOSS_V;
            alt_cnt    <= '0;
            prev_bit   <= 1'b0;
            bit_cnt    <= '0;
            shift_q    <= '0;
            stage_dat  <= '0;
            stage_full <= 1'b0;
        end else begin
            state      <= state_nxt;
            since_edge <= since_nxt;
            alt_cnt    <= alt_nxt;
            prev_bit   <= prev_nxt;
            bit_cnt    <= bcnt_nxt;
            shift_q    <= shift_nxt;
            stage_dat  <= stage_dat_nxt;
            stage_full <= stage_full_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        alt_nxt        = alt_cnt;
        prev_nxt       = prev_bit;
        bcnt_nxt       = bit_cnt;
        shift_nxt      = shift_q;
        stage_dat_nxt  = stage_dat;
        stage_full_nxt = stage_full;
        push_vld       = 1'b0;
        push_dat       = '0;

        if (mid_edge) begin
            since_nxt = SW'(1);
        end else if (since_edge == LOSS_V) begin
            since_nxt = LOSS_V;
        end else begin
            since_nxt = since_edge + SW'(1);
        end

        case (state)
            ST_IDLE: begin
                if (mid_edge) begin
                    state_nxt = ST_PREAMBLE;
                    alt_nxt   = AW'(1);
                    prev_nxt  = bit_q;
                end
            end
            ST_PREAMBLE: begin
                if (carrier_loss) begin
                    state_nxt = ST_IDLE;
                end else if (mid_edge) begin
                    prev_nxt = bit_q;
                    if (bit_q != prev_bit) begin
                        if (alt_cnt != ALT_MAX) begin
                            alt_nxt = alt_cnt + AW'(1);
                        end
                    end else if (bit_q) begin
                        // "11" is the SFD tail; only trust it after enough alternation.
                        if (alt_cnt >= ALT_MAX) begin
                            state_nxt = ST_DATA;
                            bcnt_nxt  = '0;
                        end else begin
                            state_nxt = ST_HUNT;
                        end
                    end else begin
                        alt_nxt = AW'(1);
                    end
                end
            end
            ST_HUNT: begin
                if (carrier_loss) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_DATA: begin
                if (carrier_loss) begin
                    state_nxt      = ST_IDLE;
                    push_vld       = stage_full;
                    push_dat.last  = 1'b1;
                    push_dat.data  = stage_dat;
                    stage_full_nxt = 1'b0;
                end else if (mid_edge) begin
                    shift_nxt = {bit_q, shift_q[7:1]};
                    bcnt_nxt  = bit_cnt + 3'd1;
                    // One byte of lookahead lets the final byte carry last=1.
                    if (bit_cnt == 3'd7) begin
                        push_vld       = stage_full;
                        push_dat.last  = 1'b0;
                        push_dat.data  = stage_dat;
                        stage_dat_nxt  = {bit_q, shift_q[7:1]};
                        stage_full_nxt = 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    eth_rx_manchester_fifo #(
        .WIDTH ($bits(rx_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (CLK),
        .rst_n    (RST_N),
        .push_vld (push_vld),
        .push_dat (push_dat),
        .head_vld (out_valid),
        .head_rdy (out_ready),
        .head_dat (head_dat),
        .drop     (drop)
    );

    assign out_data = head_dat.data;
    assign out_last = head_dat.last;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end
    end
endmodule

// File: tb/tb_eth_rx_manchester.sv
// Scoreboard bench for eth_rx_manchester: directed Manchester frames in, popped {last,data} compared against a queue.
module tb_eth_rx_manchester;
    localparam int OS   = 8;
    localparam int HALF = OS / 2;

    logic       clk;
    logic       rst_n;
    logic       rx_in;
    logic [7:0] out_data;
    logic       out_last;
    logic       out_valid;
    logic       out_ready;
    logic       overflow;
    logic       activity;

    int         n_tests;
    int         n_fail;
    int         rdy_mode;
    bit         jit_en;
    logic [8:0] exp_q[$];

    eth_rx_manchester #(
        .OVERSAMPLE   (OS),
        .FIFO_DEPTH   (4),
        .MIN_PREAMBLE (48),
        .IDLE_BITS    (2)
    ) dut (
        .CLK       (clk),
        .RST_N     (rst_n),
        .rx_in     (rx_in),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .overflow  (overflow),
        .activity  (activity)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic hold(input logic level, input int n);
        rx_in = level;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        int j;
        j = jit_en ? (int'($urandom_range(2)) - 1) : 0;
        hold(~b, HALF + j);
        hold(b, HALF - j);
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 0; i < 8; i++) begin
            send_bit(v[i]);
        end
    endtask

    task automatic send_preamble(input int n55);
        for (int i = 0; i < n55; i++) begin
            send_byte(8'h55);
        end
        send_byte(8'hD5);
    endtask

    task automatic expect_entry(input logic last, input logic [7:0] data);
        exp_q.push_back({last, data});
    endtask

    task automatic wait_drain(input string name);
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 400) begin
            @(negedge clk);
            t++;
        end
        check(name, exp_q.size(), 0);
    endtask

    // out_ready changes just after the rising edge so the monitor sees it settled.
    initial begin
        int ph;
        ph = 0;
        out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            case (rdy_mode)
                1:       out_ready = 1'b1;
                2:       out_ready = (ph == 0);
                default: out_ready = 1'b0;
            endcase
            ph = (ph == 2) ? 0 : ph + 1;
        end
    end

    initial begin
        logic [8:0] e;
        forever begin
            @(negedge clk);
            if (rst_n && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_pop: got last=%0b data=%02h, expected no entry", out_last, out_data);
                end else begin
                    e = exp_q.pop_front();
                    check("pop", {23'd0, out_last, out_data}, {23'd0, e});
                end
            end
        end
    end

    initial begin
        repeat (60000) @(posedge clk);
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1);
    end

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        rdy_mode = 0;
        jit_en   = 1'b0;
        rst_n    = 1'b0;
        rx_in    = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Reset asserted in the middle of a frame with a byte already queued.
        send_preamble(7);
        send_byte(8'h77);
        send_byte(8'h66);
        send_bit(1'b1);
        send_bit(1'b0);
        check("pre_reset_valid", out_valid, 1);
        rst_n = 1'b0;
        #1;
        check("reset_out_data", out_data, 0);
        check("reset_out_last", out_last, 0);
        check("reset_out_valid", out_valid, 0);
        check("reset_overflow", overflow, 0);
        check("reset_activity", activity, 0);
        send_byte(8'h99);
        check("reset_hold_activity", activity, 0);
        check("reset_hold_valid", out_valid, 0);
        rx_in = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        check("idle_activity", activity, 0);
        check("idle_valid", out_valid, 0);

        // Basic frame, consumer always ready.
        rdy_mode = 1;
        expect_entry(1'b0, 8'h01);
        expect_entry(1'b0, 8'h80);
        expect_entry(1'b0, 8'hFF);
        expect_entry(1'b1, 8'hA5);
        send_preamble(7);
        send_byte(8'h01);
        send_byte(8'h80);
        send_byte(8'hFF);
        send_byte(8'hA5);
        repeat (8) @(negedge clk);
        check("basic_activity_held", activity, 1);
        repeat (14) @(negedge clk);
        check("basic_activity_fall", activity, 0);
        wait_drain("basic_drain");

        // Preamble too short: the frame is hunted out, the next one decodes.
        send_preamble(4);
        send_byte(8'h12);
        repeat (30) @(negedge clk);
        check("short_activity", activity, 0);
        check("short_no_output", out_valid, 0);
        expect_entry(1'b1, 8'h34);
        send_preamble(7);
        send_byte(8'h34);
        repeat (30) @(negedge clk);
        wait_drain("short_drain");

        // Trailing partial byte is discarded.
        expect_entry(1'b1, 8'hAA);
        send_preamble(7);
        send_byte(8'hAA);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b0);
        repeat (30) @(negedge clk);
        wait_drain("trailing_drain");

        // Back-to-back frames with edge jitter and a 1-in-3 ready consumer.
        rdy_mode = 2;
        jit_en   = 1'b1;
        expect_entry(1'b0, 8'hDE);
        expect_entry(1'b1, 8'hAD);
        expect_entry(1'b0, 8'hBE);
        expect_entry(1'b1, 8'hEF);
        send_preamble(7);
        send_byte(8'hDE);
        send_byte(8'hAD);
        repeat (3 * OS) @(negedge clk);
        send_preamble(7);
        send_byte(8'hBE);
        send_byte(8'hEF);
        jit_en = 1'b0;
        repeat (30) @(negedge clk);
        wait_drain("b2b_drain");
        check("b2b_no_overflow", overflow, 0);

        // Overflow: 6 bytes into a 4-deep FIFO with the consumer stalled.
        rdy_mode = 0;
        expect_entry(1'b0, 8'h10);
        expect_entry(1'b0, 8'h11);
        expect_entry(1'b0, 8'h12);
        expect_entry(1'b0, 8'h13);
        send_preamble(7);
        for (int b = 8'h10; b <= 8'h15; b++) begin
            send_byte(8'(b));
        end
        repeat (30) @(negedge clk);
        check("ovf_flag", overflow, 1);
        check("ovf_valid_stalled", out_valid, 1);
        check("ovf_stall_head", {out_last, out_data}, 9'h010);
        rdy_mode = 1;
        wait_drain("ovf_drain");
        repeat (5) @(negedge clk);
        check("ovf_valid_after_drain", out_valid, 0);
        check("ovf_sticky", overflow, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
